// File: rtl/matrix_vec_stream.sv
// Streams an NxN bit matrix in row by row, then multiplies it by accepted vectors (GF(2) or Boolean).
// Latency: u_valid rises N edges after the vector-accept edge, one result bit per row per cycle.
// Backpressure: the result is held in DONE until u_ready; no new vector is accepted meanwhile.
module matrix_vec_stream #(
  parameter int N    = 4,
  parameter int MODE = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         row_valid,
  output logic         row_ready,
  input  logic [N-1:0] row_data,
  input  logic         mat_clear,
  input  logic         vec_valid,
  output logic         vec_ready,
  input  logic [N-1:0] vec_data,
  output logic         u_valid,
  input  logic         u_ready,
  output logic [N-1:0] u_data,
  output logic         mat_loaded,
  output logic         busy
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST_ROW = CW'(N - 1);

  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    IDLE    = 2'd1,
    COMPUTE = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t        state;
  logic [CW-1:0] row_cnt;
  logic [N-1:0]  mat [N];
  logic [N-1:0]  vec_q;
  logic          idle_q;
  logic [N-1:0]  prod;
  logic          row_bit;

  // mat_clear wins over a pending vector in IDLE, so the ready must see it combinationally.
  assign vec_ready = idle_q & ~mat_clear;

  always_comb begin
    prod    = mat[row_cnt] & vec_q;
    row_bit = 1'b0;
    if (MODE == 1) begin
      row_bit = |prod;
    end else begin
      row_bit = ^prod;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= LOAD;
      row_cnt    <= '0;
      for (int i = 0; i < N; i++) begin
        mat[i] <= '0;
      end
      vec_q      <= '0;
      u_data     <= '0;
      row_ready  <= 1'b1;
      idle_q     <= 1'b0;
      u_valid    <= 1'b0;
      mat_loaded <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          if (row_valid) begin
            mat[row_cnt] <= row_data;
            if (row_cnt == LAST_ROW) begin
              state      <= IDLE;
              row_cnt    <= '0;
              row_ready  <= 1'b0;
              idle_q     <= 1'b1;
              mat_loaded <= 1'b1;
            end else begin
              row_cnt <= row_cnt + 1'b1;
            end
          end
        end

        IDLE: begin
          if (mat_clear) begin
            state      <= LOAD;
            row_cnt    <= '0;
            row_ready  <= 1'b1;
            idle_q     <= 1'b0;
            mat_loaded <= 1'b0;
          end else if (vec_valid) begin
            state   <= COMPUTE;
            vec_q   <= vec_data;
            u_data  <= '0;
            row_cnt <= '0;
            idle_q  <= 1'b0;
            busy    <= 1'b1;
          end
        end

        COMPUTE: begin
          u_data[row_cnt] <= row_bit;
          if (row_cnt == LAST_ROW) begin
            state   <= DONE;
            row_cnt <= '0;
            u_valid <= 1'b1;
          end else begin
            row_cnt <= row_cnt + 1'b1;
          end
        end

        DONE: begin
          if (u_ready) begin
            state   <= IDLE;
            u_valid <= 1'b0;
            busy    <= 1'b0;
            idle_q  <= 1'b1;
          end
        end

        default: begin
          state     <= LOAD;
          row_cnt   <= '0;
          row_ready <= 1'b1;
          idle_q    <= 1'b0;
          u_valid   <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_vec_stream.sv
// Bench for matrix_vec_stream: a GF(2) and a Boolean instance share stimulus and are
// checked every cycle against a transaction-level model plus directed literal cases.
module tb_matrix_vec_stream;

  localparam int N = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n     = 1'b0;
  logic         row_valid = 1'b0;
  logic [N-1:0] row_data  = '0;
  logic         mat_clear = 1'b0;
  logic         vec_valid = 1'b0;
  logic [N-1:0] vec_data  = '0;
  logic         u_ready   = 1'b0;

  logic         row_ready_a, vec_ready_a, u_valid_a, mat_loaded_a, busy_a;
  logic [N-1:0] u_data_a;
  logic         row_ready_b, vec_ready_b, u_valid_b, mat_loaded_b, busy_b;
  logic [N-1:0] u_data_b;

  matrix_vec_stream #(.N(N), .MODE(0)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .row_valid(row_valid), .row_ready(row_ready_a), .row_data(row_data),
    .mat_clear(mat_clear),
    .vec_valid(vec_valid), .vec_ready(vec_ready_a), .vec_data(vec_data),
    .u_valid(u_valid_a), .u_ready(u_ready), .u_data(u_data_a),
    .mat_loaded(mat_loaded_a), .busy(busy_a)
  );

  matrix_vec_stream #(.N(N), .MODE(1)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .row_valid(row_valid), .row_ready(row_ready_b), .row_data(row_data),
    .mat_clear(mat_clear),
    .vec_valid(vec_valid), .vec_ready(vec_ready_b), .vec_data(vec_data),
    .u_valid(u_valid_b), .u_ready(u_ready), .u_data(u_data_b),
    .mat_loaded(mat_loaded_b), .busy(busy_b)
  );

  int total = 0;
  int bad   = 0;
  bit checking = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Matrix-vector product by counting matching ones per row.
  function automatic logic [N-1:0] mvmul(input logic [N-1:0][N-1:0] m,
                                         input logic [N-1:0] v, input int mode);
    logic [N-1:0] res;
    res = '0;
    for (int i = 0; i < N; i++) begin
      int cnt;
      cnt = 0;
      for (int j = 0; j < N; j++) begin
        if (m[i][j] && v[j]) cnt++;
      end
      res[i] = (mode == 1) ? (cnt > 0) : (cnt % 2 == 1);
    end
    return res;
  endfunction

  function automatic logic [N-1:0] low_mask(input int k);
    return N'((32'd1 << k) - 1);
  endfunction

  // Transaction-level model: rows stored so far, pending job and edges still to go.
  logic [N-1:0][N-1:0] m_mat = '0;
  logic [N-1:0]        m_vec = '0;
  int                  m_rows = 0;
  bit                  m_job  = 1'b0;
  int                  m_left = 0;
  logic [N-1:0]        m_u0 = '0;
  logic [N-1:0]        m_u1 = '0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_mat = '0; m_vec = '0; m_rows = 0; m_job = 1'b0; m_left = 0; m_u0 = '0; m_u1 = '0;
    end else if (m_rows < N) begin
      if (row_valid) begin
        m_mat[m_rows] = row_data;
        m_rows++;
      end
    end else if (!m_job) begin
      if (mat_clear) begin
        m_rows = 0;
      end else if (vec_valid) begin
        m_vec = vec_data; m_job = 1'b1; m_left = N; m_u0 = '0; m_u1 = '0;
      end
    end else if (m_left > 0) begin
      m_left--;
      m_u0 = mvmul(m_mat, m_vec, 0) & low_mask(N - m_left);
      m_u1 = mvmul(m_mat, m_vec, 1) & low_mask(N - m_left);
    end else if (u_ready) begin
      m_job = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      chk("row_ready_a",  32'(row_ready_a),  32'(m_rows < N));
      chk("row_ready_b",  32'(row_ready_b),  32'(m_rows < N));
      chk("mat_loaded_a", 32'(mat_loaded_a), 32'(m_rows == N));
      chk("mat_loaded_b", 32'(mat_loaded_b), 32'(m_rows == N));
      chk("vec_ready_a",  32'(vec_ready_a),  32'(m_rows == N && !m_job && !mat_clear));
      chk("vec_ready_b",  32'(vec_ready_b),  32'(m_rows == N && !m_job && !mat_clear));
      chk("busy_a",       32'(busy_a),       32'(m_job));
      chk("busy_b",       32'(busy_b),       32'(m_job));
      chk("u_valid_a",    32'(u_valid_a),    32'(m_job && m_left == 0));
      chk("u_valid_b",    32'(u_valid_b),    32'(m_job && m_left == 0));
      chk("u_data_a",     32'(u_data_a),     32'(m_u0));
      chk("u_data_b",     32'(u_data_b),     32'(m_u1));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load3(input logic [N-1:0] r0, input logic [N-1:0] r1, input logic [N-1:0] r2);
    row_valid = 1'b1;
    row_data = r0; step();
    row_data = r1; step();
    row_data = r2; step();
    row_valid = 1'b0;
  endtask

  task automatic run_vec(input logic [N-1:0] v);
    int lat;
    vec_valid = 1'b1;
    vec_data  = v;
    step();
    vec_valid = 1'b0;
    lat = 0;
    while (!u_valid_a && lat < 40) begin
      step();
      lat++;
    end
    chk("latency", 32'(lat), 32'(N));
  endtask

  task automatic take_result();
    u_ready = 1'b1;
    step();
    u_ready = 1'b0;
  endtask

  logic [N-1:0][N-1:0] pin_m;

  initial begin
    // Model pins against hand-computed products.
    pin_m[0] = 3'b001; pin_m[1] = 3'b010; pin_m[2] = 3'b100;
    chk("pin_ident_gf2", 32'(mvmul(pin_m, 3'b101, 0)), 32'h5);
    pin_m[0] = 3'b111; pin_m[1] = 3'b111; pin_m[2] = 3'b111;
    chk("pin_ones_gf2",  32'(mvmul(pin_m, 3'b011, 0)), 32'h0);
    chk("pin_ones_bool", 32'(mvmul(pin_m, 3'b011, 1)), 32'h7);

    rst_n = 1'b0;
    step();
    checking = 1'b1;
    step();
    chk("rst_row_ready",  32'(row_ready_a),  32'h1);
    chk("rst_vec_ready",  32'(vec_ready_a),  32'h0);
    chk("rst_u_valid",    32'(u_valid_a),    32'h0);
    chk("rst_u_data",     32'(u_data_a),     32'h0);
    chk("rst_mat_loaded", 32'(mat_loaded_a), 32'h0);
    chk("rst_busy",       32'(busy_a),       32'h0);
    rst_n = 1'b1;

    // Identity matrix, then a held result.
    load3(3'b001, 3'b010, 3'b100);
    chk("loaded", 32'(mat_loaded_a), 32'h1);
    run_vec(3'b101);
    chk("ident_u_a", 32'(u_data_a), 32'h5);
    chk("ident_u_b", 32'(u_data_b), 32'h5);
    for (int k = 0; k < 5; k++) begin
      step();
      chk("hold_u_valid",   32'(u_valid_a),   32'h1);
      chk("hold_u_data",    32'(u_data_a),    32'h5);
      chk("hold_vec_ready", 32'(vec_ready_a), 32'h0);
    end
    take_result();
    chk("after_u_valid",   32'(u_valid_a),   32'h0);
    chk("after_vec_ready", 32'(vec_ready_a), 32'h1);
    chk("after_u_data",    32'(u_data_a),    32'h5);

    // Stray row in IDLE, then two back-to-back vectors on the same matrix.
    row_valid = 1'b1; row_data = 3'b111;
    step();
    row_valid = 1'b0;
    run_vec(3'b110);
    chk("b2b1_u_a", 32'(u_data_a), 32'h6);
    take_result();
    run_vec(3'b011);
    chk("b2b2_u_a", 32'(u_data_a), 32'h3);
    chk("b2b2_u_b", 32'(u_data_b), 32'h3);
    take_result();

    // mat_clear beats a concurrent vector; vec_valid held through LOAD.
    mat_clear = 1'b1; vec_valid = 1'b1; vec_data = 3'b111;
    #1;
    chk("clr_vec_ready", 32'(vec_ready_a), 32'h0);
    step();
    mat_clear = 1'b0;
    chk("clr_row_ready",  32'(row_ready_a),  32'h1);
    chk("clr_mat_loaded", 32'(mat_loaded_a), 32'h0);
    chk("clr_busy",       32'(busy_a),       32'h0);
    load3(3'b111, 3'b111, 3'b111);
    vec_valid = 1'b0;
    chk("ld_busy", 32'(busy_a), 32'h0);
    run_vec(3'b011);
    chk("ones_u_a", 32'(u_data_a), 32'h0);
    chk("ones_u_b", 32'(u_data_b), 32'h7);
    take_result();

    // Reset during the second COMPUTE cycle.
    vec_valid = 1'b1; vec_data = 3'b111;
    step();
    vec_valid = 1'b0;
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("midrst_row_ready",  32'(row_ready_a),  32'h1);
    chk("midrst_u_valid",    32'(u_valid_a),    32'h0);
    chk("midrst_mat_loaded", 32'(mat_loaded_a), 32'h0);
    chk("midrst_u_data",     32'(u_data_a),     32'h0);

    // Random traffic, checked every cycle by the model.
    for (int c = 0; c < 3000; c++) begin
      rst_n     = ($urandom_range(0, 99) != 0);
      row_valid = $urandom_range(0, 1) == 1;
      row_data  = N'($urandom);
      mat_clear = ($urandom_range(0, 7) == 0);
      vec_valid = $urandom_range(0, 1) == 1;
      vec_data  = N'($urandom);
      u_ready   = $urandom_range(0, 1) == 1;
      step();
    end

    checking = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/matrix_vec_stream.md
MATRIX_VEC_STREAM -- requirements
Module: matrix_vec_stream

Interface
REQ-001 Parameter N, default 4: matrix dimension and vector length, legal range 2..16.
REQ-002 Parameter MODE, default 0: 0 = GF(2) product (AND/XOR), 1 = Boolean product (AND/OR).
REQ-003 The block SHALL use one clock; reset is synchronous and active-low.
REQ-004 clk  in  1  rising-edge clock for all state.
REQ-005 rst_n  in  1  synchronous active-low reset.
REQ-006 row_valid  in  1  row_data holds a valid matrix row.
REQ-007 row_ready  out  1  block accepts a matrix row.
REQ-008 row_data  in  N  one matrix row; bit j = M[r][j].
REQ-009 mat_clear  in  1  discards the loaded matrix and returns to row loading.
REQ-010 vec_valid  in  1  vec_data holds a valid vector.
REQ-011 vec_ready  out  1  block accepts a vector.
REQ-012 vec_data  in  N  vector v; bit j = v[j].
REQ-013 u_valid  out  1  u_data holds a completed result.
REQ-014 u_ready  in  1  consumer accepts the result.
REQ-015 u_data  out  N  result u; bit i = u[i].
REQ-016 mat_loaded  out  1  all N rows are stored.
REQ-017 busy  out  1  high in COMPUTE or DONE.

Function
REQ-018 The FSM SHALL have exactly four states: LOAD, IDLE, COMPUTE, DONE.
REQ-019 A transfer SHALL occur on a rising edge only when the relevant valid and ready are both high.
REQ-020 LOAD: row_ready=1; each row transfer stores row_data into row r (r = row counter, starting at 0) and increments r; the N-th transfer (r=N-1) SHALL move to IDLE with mat_loaded=1.
REQ-021 IDLE: vec_ready = ~mat_clear; a vector transfer SHALL latch vec_data, clear the result register, zero the row counter and move to COMPUTE.
REQ-022 IDLE with mat_clear=1: move to LOAD, r=0, mat_loaded=0, no vector accepted even if vec_valid=1.
REQ-023 mat_clear SHALL be ignored in LOAD, COMPUTE and DONE.
REQ-024 COMPUTE: one row per cycle; at edge for row i, u[i] = XOR over j of (M[i][j] AND v[j]) if MODE=0, OR over j if MODE=1; after row N-1 move to DONE.
REQ-025 Latency: u_valid SHALL rise exactly N clock edges after the vector-accept edge.
REQ-026 DONE: u_valid=1; u_data stable until u_ready=1, then return to IDLE on that edge.
REQ-027 row_ready, vec_ready SHALL be 0 outside LOAD and IDLE respectively; row_valid outside LOAD and vec_valid outside IDLE SHALL have no effect.
REQ-028 The stored matrix SHALL persist across any number of vector operations until mat_clear or reset.
REQ-029 u_data SHALL retain the last result after leaving DONE until the next vector is accepted.
REQ-030 Row and state counters SHALL never exceed N-1; no wrap occurs beyond row N-1.

Reset
REQ-031 rst_n=0 at a rising edge SHALL, from any state including mid-COMPUTE or DONE, force LOAD, r=0, matrix, vector and u_data to all zeros.
REQ-032 Reset outputs: row_ready=1, vec_ready=0, u_valid=0, u_data=0, mat_loaded=0, busy=0.
REQ-033 Reset SHALL take priority over every handshake and mat_clear on the same edge.

Verification
REQ-034 N=3, MODE=0: load rows 3'b001, 3'b010, 3'b100, v=3'b101 -> u_valid 3 edges after accept, u_data=3'b101.
REQ-035 N=3: rows all 3'b111, v=3'b011 -> MODE=0 gives u_data=3'b000; MODE=1 gives 3'b111.
REQ-036 Hold u_ready=0 for 5 cycles in DONE -> u_valid=1, u_data unchanged, vec_ready=0 throughout; u_ready=1 -> IDLE next cycle.
REQ-037 Assert rst_n=0 on second COMPUTE cycle -> next cycle row_ready=1, u_valid=0, mat_loaded=0, u_data=0.
REQ-038 In IDLE drive mat_clear=1 with vec_valid=1 -> vec_ready=0, no vector accepted, state LOAD, mat_loaded=0.
REQ-039 Drive row_valid=1 in IDLE and vec_valid=1 in LOAD -> matrix and vector registers unchanged; two back-to-back vectors on one matrix yield two correct results.
